// File: rtl/decode_stage_p_if.sv
`default_nettype none
// decode_if: IF/ID-side, write-back and ID/EX-side signals of decode_stage_p.
// Rev 1.0
interface decode_if #(
  parameter int DATA_W     = 16,
  parameter int INSTR_W    = 16,
  parameter int REG_ADDR_W = 3,
  parameter int CNT_W      = 8
);
  logic                  in_valid;
  logic [INSTR_W-1:0]    instruction;
  logic                  wb_en;
  logic [REG_ADDR_W-1:0] wb_addr;
  logic [DATA_W-1:0]     wb_data;
  logic                  ex_stall;
  logic                  flush;
  logic                  id_stall;
  logic                  ex_valid;
  logic [10:0]           ex_ctrl;
  logic [DATA_W-1:0]     ex_rdata1;
  logic [DATA_W-1:0]     ex_rdata2;
  logic [REG_ADDR_W-1:0] ex_rs1;
  logic [REG_ADDR_W-1:0] ex_rs2;
  logic [REG_ADDR_W-1:0] ex_rd;
  logic [CNT_W-1:0]      bubble_cnt;

  modport master (
    output in_valid, instruction, wb_en, wb_addr, wb_data, ex_stall, flush,
    input  id_stall, ex_valid, ex_ctrl, ex_rdata1, ex_rdata2, ex_rs1, ex_rs2, ex_rd, bubble_cnt
  );

  modport slave (
    input  in_valid, instruction, wb_en, wb_addr, wb_data, ex_stall, flush,
    output id_stall, ex_valid, ex_ctrl, ex_rdata1, ex_rdata2, ex_rs1, ex_rs2, ex_rd, bubble_cnt
  );
endinterface
`default_nettype wire

// File: rtl/decode_stage_p.sv
`default_nettype none
// decode_stage_p: CU decode, bypassed register file, load-use bubbling and ID/EX register.
// Rev 1.0
module CU (
  input  logic [2:0]  opcode_i,
  output logic [10:0] ctrl_o
);
  // bits: 0 ALU_OP 1 ALU_src 2 MEMW 3 MEMR 4 MTR 5 Branch 6 reg_write 7 In 8 Out 9 Stack_op 10 Push
  always_comb begin
    ctrl_o = '0;
    case (opcode_i)
      3'd0: begin ctrl_o[0] = 1'b1; ctrl_o[6] = 1'b1; end
      3'd1: begin ctrl_o[0] = 1'b1; ctrl_o[1] = 1'b1; ctrl_o[6] = 1'b1; end
      3'd2: begin ctrl_o[1] = 1'b1; ctrl_o[3] = 1'b1; ctrl_o[4] = 1'b1; ctrl_o[6] = 1'b1; end
      3'd3: begin ctrl_o[1] = 1'b1; ctrl_o[2] = 1'b1; end
      3'd4: begin ctrl_o[5] = 1'b1; end
      3'd5: begin ctrl_o[6] = 1'b1; ctrl_o[7] = 1'b1; end
      3'd6: begin ctrl_o[8] = 1'b1; end
      default: begin ctrl_o[2] = 1'b1; ctrl_o[9] = 1'b1; ctrl_o[10] = 1'b1; end
    endcase
  end
endmodule

module decode_stage_p #(
  parameter int DATA_W     = 16,
  parameter int INSTR_W    = 16,
  parameter int OPC_W      = 3,
  parameter int REG_ADDR_W = 3,
  parameter int CNT_W      = 8
) (
  input logic     clk,
  input logic     rst_n,
  decode_if.slave bus
);
  localparam int NREG  = 2**REG_ADDR_W;
  localparam int LOW_W = INSTR_W - OPC_W - 2*REG_ADDR_W;

  logic [OPC_W-1:0]      opc;
  logic [REG_ADDR_W-1:0] rs1, rs2;
  logic [10:0]           cu_ctrl;
  logic [DATA_W-1:0]     rdata1, rdata2;
  logic                  load_use;
  logic                  unused_bits;

  logic [DATA_W-1:0]     rf_q [NREG];

  logic                  ex_valid_q, ex_valid_d;
  logic [10:0]           ex_ctrl_q, ex_ctrl_d;
  logic [DATA_W-1:0]     ex_rdata1_q, ex_rdata1_d;
  logic [DATA_W-1:0]     ex_rdata2_q, ex_rdata2_d;
  logic [REG_ADDR_W-1:0] ex_rs1_q, ex_rs1_d;
  logic [REG_ADDR_W-1:0] ex_rs2_q, ex_rs2_d;
  logic [REG_ADDR_W-1:0] ex_rd_q, ex_rd_d;
  logic [CNT_W-1:0]      bubble_cnt_q, bubble_cnt_d;

  assign opc         = bus.instruction[INSTR_W-1 -: OPC_W];
  assign rs1         = bus.instruction[INSTR_W-OPC_W-1 -: REG_ADDR_W];
  assign rs2         = bus.instruction[INSTR_W-OPC_W-REG_ADDR_W-1 -: REG_ADDR_W];
  assign unused_bits = ^bus.instruction[LOW_W-1:0];

  CU u_cu (
    .opcode_i (opc),
    .ctrl_o   (cu_ctrl)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++) rf_q[i] <= '0;
    end else if (bus.wb_en) begin
      rf_q[bus.wb_addr] <= bus.wb_data;
    end
  end

  // Same-cycle write-back wins over storage so a dependent decode sees fresh data.
  assign rdata1 = (bus.wb_en && bus.wb_addr == rs1) ? bus.wb_data : rf_q[rs1];
  assign rdata2 = (bus.wb_en && bus.wb_addr == rs2) ? bus.wb_data : rf_q[rs2];

  assign load_use = bus.in_valid & ex_valid_q & ex_ctrl_q[3] & ex_ctrl_q[6]
                  & ((ex_rd_q == rs1) | (ex_rd_q == rs2));

  assign bus.id_stall = rst_n & (bus.ex_stall | load_use) & ~bus.flush;

  always_comb begin
    ex_valid_d   = ex_valid_q;
    ex_ctrl_d    = ex_ctrl_q;
    ex_rdata1_d  = ex_rdata1_q;
    ex_rdata2_d  = ex_rdata2_q;
    ex_rs1_d     = ex_rs1_q;
    ex_rs2_d     = ex_rs2_q;
    ex_rd_d      = ex_rd_q;
    bubble_cnt_d = bubble_cnt_q;
    if (bus.flush || (!bus.ex_stall && load_use)) begin
      ex_valid_d  = 1'b0;
      ex_ctrl_d   = '0;
      ex_rdata1_d = '0;
      ex_rdata2_d = '0;
      ex_rs1_d    = '0;
      ex_rs2_d    = '0;
      ex_rd_d     = '0;
      if (!bus.flush && bubble_cnt_q != {CNT_W{1'b1}})
        bubble_cnt_d = bubble_cnt_q + CNT_W'(1);
    end else if (!bus.ex_stall) begin
      ex_valid_d  = bus.in_valid;
      ex_ctrl_d   = bus.in_valid ? cu_ctrl : 11'd0;
      ex_rdata1_d = rdata1;
      ex_rdata2_d = rdata2;
      ex_rs1_d    = rs1;
      ex_rs2_d    = rs2;
      ex_rd_d     = rs1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_valid_q   <= 1'b0;
      ex_ctrl_q    <= '0;
      ex_rdata1_q  <= '0;
      ex_rdata2_q  <= '0;
      ex_rs1_q     <= '0;
      ex_rs2_q     <= '0;
      ex_rd_q      <= '0;
      bubble_cnt_q <= '0;
    end else begin
      ex_valid_q   <= ex_valid_d;
      ex_ctrl_q    <= ex_ctrl_d;
      ex_rdata1_q  <= ex_rdata1_d;
      ex_rdata2_q  <= ex_rdata2_d;
      ex_rs1_q     <= ex_rs1_d;
      ex_rs2_q     <= ex_rs2_d;
      ex_rd_q      <= ex_rd_d;
      bubble_cnt_q <= bubble_cnt_d;
    end
  end

  assign bus.ex_valid   = ex_valid_q;
  assign bus.ex_ctrl    = ex_ctrl_q;
  assign bus.ex_rdata1  = ex_rdata1_q;
  assign bus.ex_rdata2  = ex_rdata2_q;
  assign bus.ex_rs1     = ex_rs1_q;
  assign bus.ex_rs2     = ex_rs2_q;
  assign bus.ex_rd      = ex_rd_q;
  assign bus.bubble_cnt = bubble_cnt_q;
endmodule
`default_nettype wire

// File: tb/tb_decode_stage_p.sv
`default_nettype none
// tb_decode_stage_p: scoreboard bench for decode_stage_p with a slot-level reference model.
// Rev 1.0
module tb_decode_stage_p;
  localparam int DW = 16, IW = 16, OW = 3, AW = 3, CW = 2;
  localparam int SAT = (1 << CW) - 1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  decode_if #(.DATA_W(DW), .INSTR_W(IW), .REG_ADDR_W(AW), .CNT_W(CW)) bus ();

  decode_stage_p #(.DATA_W(DW), .INSTR_W(IW), .OPC_W(OW), .REG_ADDR_W(AW), .CNT_W(CW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    logic          v;
    logic [10:0]   ctrl;
    logic [DW-1:0] d1, d2;
    logic [AW-1:0] rs1, rs2, rd;
    logic          dc;
    int            bc;
  } slot_t;

  // Control word per opcode: ALU, ALUI, LOAD, STORE, BRANCH, IN, OUT, PUSH
  logic [10:0] cu_tab [8] = '{11'h041, 11'h043, 11'h05A, 11'h006, 11'h020, 11'h0C0, 11'h100, 11'h604};

  slot_t         exp_q[$];
  slot_t         m;
  logic [DW-1:0] mrf [8];
  int            checks = 0;
  int            errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void model_reset();
    m = '{default: 0};
    for (int i = 0; i < 8; i++) mrf[i] = '0;
  endfunction

  function automatic logic [IW-1:0] mk(input int op, input int r1, input int r2);
    logic [IW-1:0] w;
    w = {3'(op), 3'(r1), 3'(r2), 7'($urandom)};
    return w;
  endfunction

  task automatic drive(input logic iv, input logic [IW-1:0] ins, input logic we,
                       input logic [AW-1:0] wa, input logic [DW-1:0] wd,
                       input logic st, input logic fl, output logic stall_exp);
    slot_t n;
    logic [2:0] op, r1, r2;
    logic lu;
    @(negedge clk);
    bus.in_valid = iv; bus.instruction = ins; bus.wb_en = we; bus.wb_addr = wa;
    bus.wb_data = wd; bus.ex_stall = st; bus.flush = fl;
    op = ins[15:13]; r1 = ins[12:10]; r2 = ins[9:7];
    lu = iv && m.v && m.ctrl[3] && m.ctrl[6] && (m.rd == r1 || m.rd == r2);
    stall_exp = (st || lu) && !fl;
    #1 chk("id_stall", 32'(bus.id_stall), 32'(stall_exp));
    n = m;
    if (fl) begin
      n = '{default: 0};
      n.bc = m.bc;
    end else if (st) begin
      n = m;
    end else if (lu) begin
      n.v = 1'b0; n.ctrl = '0; n.dc = 1'b1;
      if (n.bc < SAT) n.bc++;
    end else begin
      n.v    = iv;
      n.ctrl = iv ? cu_tab[op] : 11'd0;
      n.d1   = (we && wa == r1) ? wd : mrf[r1];
      n.d2   = (we && wa == r2) ? wd : mrf[r2];
      n.rs1 = r1; n.rs2 = r2; n.rd = r1; n.dc = 1'b0;
    end
    exp_q.push_back(n);
    @(posedge clk);
    if (we) mrf[wa] = wd;
    m = n;
  endtask

  // Monitor: compares the ID/EX slot presented after every edge with the oldest expectation.
  initial begin
    slot_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("ex_valid",   32'(bus.ex_valid),   32'(e.v));
        chk("ex_ctrl",    32'(bus.ex_ctrl),    32'(e.ctrl));
        chk("bubble_cnt", 32'(bus.bubble_cnt), 32'(e.bc));
        if (!e.dc) begin
          chk("ex_rdata1", 32'(bus.ex_rdata1), 32'(e.d1));
          chk("ex_rdata2", 32'(bus.ex_rdata2), 32'(e.d2));
          chk("ex_rs1",    32'(bus.ex_rs1),    32'(e.rs1));
          chk("ex_rs2",    32'(bus.ex_rs2),    32'(e.rs2));
          chk("ex_rd",     32'(bus.ex_rd),     32'(e.rd));
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    logic s, hold, iv;
    logic [IW-1:0] ins;
    model_reset();
    bus.in_valid = 0; bus.instruction = '0; bus.wb_en = 0; bus.wb_addr = '0;
    bus.wb_data = '0; bus.ex_stall = 1; bus.flush = 0;
    #12;
    chk("reset id_stall",   32'(bus.id_stall),   0);
    chk("reset ex_valid",   32'(bus.ex_valid),   0);
    chk("reset ex_ctrl",    32'(bus.ex_ctrl),    0);
    chk("reset ex_rdata1",  32'(bus.ex_rdata1),  0);
    chk("reset bubble_cnt", 32'(bus.bubble_cnt), 0);
    @(negedge clk); bus.ex_stall = 0; #1 rst_n = 1'b1;

    // Write R5 and decode rs1=5 in the same cycle: bypass
    drive(1, mk(0, 5, 1), 1, 3'd5, 16'h1234, 0, 0, s);
    // Load-use: load rd=2, dependent on rs2, held instruction reissues
    drive(1, mk(2, 2, 0), 0, 0, 0, 0, 0, s);
    drive(1, mk(0, 3, 2), 1, 3'd6, 16'hBEEF, 0, 0, s);
    drive(1, mk(0, 3, 2), 0, 0, 0, 0, 0, s);
    // Downstream stall for 3 cycles
    drive(1, mk(1, 4, 5), 0, 0, 0, 0, 0, s);
    for (int k = 0; k < 3; k++) drive(1, mk(0, 1, 1), 1, 3'(k), 16'(k + 7), 1, 0, s);
    // Flush beats stall and load-use
    drive(1, mk(2, 4, 0), 0, 0, 0, 0, 0, s);
    drive(1, mk(0, 4, 4), 0, 0, 0, 1, 1, s);
    // Four more bubbles: counter saturates
    for (int k = 0; k < 4; k++) begin
      drive(1, mk(2, 1, 0), 0, 0, 0, 0, 0, s);
      drive(1, mk(0, 0, 1), 0, 0, 0, 0, 0, s);
      drive(1, mk(0, 0, 1), 0, 0, 0, 0, 0, s);
    end

    hold = 0; iv = 0; ins = '0;
    for (int k = 0; k < 1500; k++) begin
      if (!hold) begin
        iv  = ($urandom_range(0, 9) != 0);
        ins = mk(($urandom_range(0, 2) == 0) ? 2 : int'($urandom_range(0, 7)),
                 int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
      end
      drive(iv, ins, 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), 16'($urandom),
            ($urandom_range(0, 9) == 0), ($urandom_range(0, 19) == 0), hold);
    end

    // Asynchronous reset between edges while ID/EX holds a valid instruction
    drive(1, mk(0, 1, 2), 1, 3'd1, 16'h5A5A, 0, 0, s);
    @(negedge clk);
    bus.ex_stall = 1; bus.wb_en = 0;
    #1 rst_n = 1'b0;
    #1;
    chk("async ex_valid",   32'(bus.ex_valid),   0);
    chk("async ex_ctrl",    32'(bus.ex_ctrl),    0);
    chk("async ex_rdata1",  32'(bus.ex_rdata1),  0);
    chk("async bubble_cnt", 32'(bus.bubble_cnt), 0);
    chk("async id_stall",   32'(bus.id_stall),   0);
    #1 rst_n = 1'b1;
    model_reset();
    drive(1, mk(0, 1, 5), 0, 0, 0, 0, 0, s);
    for (int k = 0; k < 200; k++) begin
      drive(1, mk(int'($urandom_range(0, 7)), int'($urandom_range(0, 7)), int'($urandom_range(0, 7))),
            1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), 16'($urandom), 0, 0, s);
    end

    @(negedge clk);
    chk("scoreboard drained", 32'(exp_q.size()), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
`default_nettype wire
